// File: rtl/clk_seq_ctrl.sv
// clk_seq_ctrl: lock-qualified reset sequencer with CPU clock-enable and display-scan tick.
// Define CLK_SEQ_STEP_EN to add single-step CPU control via run_mode/step_req.
module clk_seq_ctrl #(
    parameter int SETTLE_CYC = 1024,
    parameter int PERIPH_GAP = 16,
    parameter int DIV_CPU    = 4,
    parameter int SCAN_DIV   = 200000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       run_mode,
    input  logic       step_req,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic       cpu_ce,
    output logic       scan_ce,
    output logic [1:0] seq_state,
    output logic       ready
);
    localparam int CMAX = SETTLE_CYC > PERIPH_GAP ? SETTLE_CYC : PERIPH_GAP;
    localparam int CW = $clog2(CMAX + 1);
    localparam int DW = $clog2(DIV_CPU + 1);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(PERIPH_GAP - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV_CPU - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {WAIT_LOCK = 2'd0, SETTLE = 2'd1, REL_PERIPH = 2'd2, RUN = 2'd3} state_t;

    state_t        st, nxt;
    logic          lk_m, lk_s;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DW-1:0] dcnt;
    logic [SW-1:0] scnt;
    logic          run_nxt, live_nxt, div_hit, div_clr, ce_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {lk_s, lk_m} <= 2'b00;
        else {lk_s, lk_m} <= {lk_m, locked};

    // Loss of lock overrides every other transition and clears the phase counter.
    always_comb begin
        nxt = st;
        cnt_nxt = '0;
        if (!lk_s) nxt = WAIT_LOCK;
        else
            case (st)
                WAIT_LOCK:  nxt = SETTLE;
                SETTLE:     if (cnt == SETTLE_LAST) nxt = REL_PERIPH; else cnt_nxt = cnt + 1'b1;
                REL_PERIPH: if (cnt == GAP_LAST) nxt = RUN; else cnt_nxt = cnt + 1'b1;
                default:    nxt = RUN;
            endcase
    end

    assign run_nxt  = nxt == RUN;
    assign live_nxt = nxt == REL_PERIPH || nxt == RUN;
    assign div_hit  = dcnt == DIV_LAST;

`ifdef CLK_SEQ_STEP_EN
    logic rm_q, st_q, mode_chg;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {rm_q, st_q} <= 2'b00;
        else {rm_q, st_q} <= {run_mode, step_req};
    assign mode_chg = run_mode != rm_q;
    assign div_clr  = mode_chg;
    assign ce_nxt   = !mode_chg && (run_mode ? div_hit : step_req && !st_q);
`else
    logic unused_step;
    assign unused_step = ^{run_mode, step_req};
    assign div_clr = 1'b0;
    assign ce_nxt  = div_hit;
`endif

    // Outputs are registered from the next state so they align with seq_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= WAIT_LOCK;
            cnt        <= '0;
            dcnt       <= '0;
            scnt       <= '0;
            periph_rst <= 1'b1;
            cpu_rst    <= 1'b1;
            ready      <= 1'b0;
            cpu_ce     <= 1'b0;
            scan_ce    <= 1'b0;
        end else begin
            st         <= nxt;
            cnt        <= cnt_nxt;
            periph_rst <= !live_nxt;
            cpu_rst    <= !run_nxt;
            ready      <= run_nxt;
            dcnt       <= (!run_nxt || div_clr || div_hit) ? '0 : dcnt + 1'b1;
            cpu_ce     <= run_nxt && ce_nxt;
            scnt       <= (!live_nxt || scnt == SCAN_LAST) ? '0 : scnt + 1'b1;
            scan_ce    <= live_nxt && scnt == SCAN_LAST;
        end
    end

    assign seq_state = st;
endmodule

// File: tb/tb_clk_seq_ctrl.sv
// tb_clk_seq_ctrl: randomized bench for clk_seq_ctrl against a run-length reference model.
module tb_clk_seq_ctrl;
    localparam int S = 8, G = 4, D = 4, SC = 5;
    localparam bit STEP =
`ifdef CLK_SEQ_STEP_EN
        1'b1;
`else
        1'b0;
`endif

    logic clk = 1'b0, rst_n = 1'b0, locked = 1'b0, run_mode = 1'b1, step_req = 1'b0;
    logic periph_rst, cpu_rst, cpu_ce, scan_ce, ready;
    logic [1:0] seq_state;
    logic p1, c1, ce1, sc1, r1;
    logic [1:0] ss1;
    int n_cmp = 0, n_err = 0;

    clk_seq_ctrl #(.SETTLE_CYC(S), .PERIPH_GAP(G), .DIV_CPU(D), .SCAN_DIV(SC)) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .run_mode(run_mode), .step_req(step_req),
        .periph_rst(periph_rst), .cpu_rst(cpu_rst), .cpu_ce(cpu_ce), .scan_ce(scan_ce),
        .seq_state(seq_state), .ready(ready));

    clk_seq_ctrl #(.SETTLE_CYC(S), .PERIPH_GAP(G), .DIV_CPU(1), .SCAN_DIV(SC)) dut1 (
        .clk(clk), .rst_n(rst_n), .locked(locked), .run_mode(run_mode), .step_req(step_req),
        .periph_rst(p1), .cpu_rst(c1), .cpu_ce(ce1), .scan_ce(sc1),
        .seq_state(ss1), .ready(r1));

    always #5 clk = ~clk;

    // Model: h counts consecutive edges with synchronized lock; phase follows from h alone.
    int h, since;
    logic [1:0] lq;
    logic rm_p, st_p;
    logic [1:0] e_st;
    logic e_pr, e_cr, e_rd, e_ce, e_sc, e_ce1;
    always @(posedge clk or negedge rst_n) begin : model
        int hn, ph, sn;
        logic chg, free, rise;
        if (!rst_n) begin
            h <= 0; since <= 0; lq <= 2'b00; rm_p <= 1'b0; st_p <= 1'b0;
            e_st <= 2'd0; e_pr <= 1'b1; e_cr <= 1'b1; e_rd <= 1'b0;
            e_ce <= 1'b0; e_sc <= 1'b0; e_ce1 <= 1'b0;
        end else begin
            hn = lq[1] ? h + 1 : 0;
            ph = hn == 0 ? 0 : hn <= S ? 1 : hn <= S + G ? 2 : 3;
            chg = STEP && (run_mode != rm_p);
            sn = chg ? 0 : (hn == S + G + 1) ? 1 : since + 1;
            free = !STEP || run_mode;
            rise = step_req && !st_p;
            h <= hn; since <= sn; lq <= {lq[0], locked};
            rm_p <= run_mode; st_p <= step_req;
            e_st <= 2'(ph);
            e_pr <= ph < 2;
            e_cr <= ph != 3;
            e_rd <= ph == 3;
            e_ce <= ph == 3 && !chg && (free ? (sn % D == 0) : rise);
            e_ce1 <= ph == 3 && !chg && (free || rise);
            e_sc <= ph >= 2 && ((hn - S) % SC == 0);
        end
    end

    logic [7:0] obs, exp_v;
    assign obs   = {seq_state, periph_rst, cpu_rst, ready, cpu_ce, scan_ce, ce1};
    assign exp_v = {e_st, e_pr, e_cr, e_rd, e_ce, e_sc, e_ce1};

    task automatic test_reset();
        rst_n = 1'b0; locked = 1'b1; run_mode = 1'b1; step_req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs !== 8'b0011_0000) begin
            n_err++; $display("FAIL reset_state: got %b want %b", obs, 8'b0011_0000);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        int pf = 0, cf = 0;
        logic [7:0] trail = 8'h00;
        logic [1:0] last = 2'd0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL sequence cyc%0d: got %b want %b", i, obs, exp_v); end
            if (!periph_rst && pf == 0) pf = i;
            if (!cpu_rst && cf == 0) cf = i;
            if (seq_state != last) begin trail = {trail[5:0], seq_state}; last = seq_state; end
        end
        n_cmp++;
        if (pf != S + 3) begin n_err++; $display("FAIL periph_latency: got %0d want %0d", pf, S + 3); end
        n_cmp++;
        if (cf - pf != G) begin n_err++; $display("FAIL cpu_gap: got %0d want %0d", cf - pf, G); end
        n_cmp++;
        if (trail !== 8'b00_01_10_11) begin n_err++; $display("FAIL state_trail: got %b want %b", trail, 8'b00011011); end
    endtask

    task automatic test_free_run();
        int n4 = 0, n1 = 0;
        run_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL free_run cyc%0d: got %b want %b", i, obs, exp_v); end
            n4 += int'(cpu_ce); n1 += int'(ce1);
        end
        n_cmp++;
        if (n4 != 40 / D) begin n_err++; $display("FAIL div4_count: got %0d want %0d", n4, 40 / D); end
        n_cmp++;
        if (n1 != 40) begin n_err++; $display("FAIL div1_count: got %0d want 40", n1); end
    endtask

    task automatic test_step();
        int got = 0, want = 0;
        run_mode = 1'b0; step_req = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL step cyc%0d: got %b want %b", i, obs, exp_v); end
            got += int'(cpu_ce); want += int'(e_ce);
            step_req = (i >= 3 && i < 13) || (i >= 18 && i < 28);
        end
        n_cmp++;
        if (STEP ? got != 2 : got != want) begin
            n_err++; $display("FAIL step_count: got %0d want %0d", got, STEP ? 2 : want);
        end
    endtask

    task automatic test_lock_drop(input logic [1:0] target);
        logic found = 1'b0;
        locked = 1'b1;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL drop_wait cyc%0d: got %b want %b", i, obs, exp_v); end
            found = seq_state == target;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL drop_reach: state %0d never reached, at %0d", target, seq_state); end
        locked = 1'b0;
        @(negedge clk);
        locked = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3 && !found; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL drop_fall cyc%0d: got %b want %b", i, obs, exp_v); end
            found = seq_state == 2'd0;
        end
        n_cmp++;
        if (!found || !periph_rst || !cpu_rst || cpu_ce) begin
            n_err++; $display("FAIL drop_to_wait: got st=%0d pr=%b cr=%b ce=%b want st=0 pr=1 cr=1 ce=0",
                              seq_state, periph_rst, cpu_rst, cpu_ce);
        end
    endtask

    task automatic test_async_reset();
        logic found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL arst_wait cyc%0d: got %b want %b", i, obs, exp_v); end
            found = seq_state == 2'd2;
        end
        n_cmp++;
        if (!found) begin n_err++; $display("FAIL arst_reach: REL_PERIPH never reached, at %0d", seq_state); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 8'b0011_0000) begin n_err++; $display("FAIL arst_immediate: got %b want %b", obs, 8'b0011_0000); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL arst_restart cyc%0d: got %b want %b", i, obs, exp_v); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            n_cmp++;
            if (obs !== exp_v) begin n_err++; $display("FAIL random cyc%0d: got %b want %b", i, obs, exp_v); end
            if ($urandom_range(0, 15) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 3) == 0) step_req = ~step_req;
            locked = $urandom_range(0, 149) != 0;
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_free_run();
        test_step();
        test_lock_drop(2'd3);
        test_lock_drop(2'd1);
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
